// File: rtl/ram_controller.sv
// Layer weight fetcher: bursts WORDS RAM reads and forwards them as weight-register writes.
// Optional running checksum is enabled by defining RAM_CTRL_CHECKSUM_EN.
module ram_controller #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int WORDS  = 16,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        layer,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [DATA_W-1:0] wr_data,
  output logic              ram_done,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic                ram_en_q, ram_en_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                accept_s;
  logic [ADDR_W-1:0]   base_s;

  assign accept_s = (state_q == S_IDLE) && start;
  assign base_s   = ADDR_W'(layer) * ADDR_W'(WORDS);

  // Next-state logic; outputs are registered from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (layer == 2'd3) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = base_s;
            idx_d   = '0;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ram_en_d = (state_d == S_ISSUE);
    wr_en_d  = ram_en_q;
    wr_idx_d = ram_en_q ? idx_q : wr_idx_q;
    done_d   = (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE);
    data_d   = wr_en_q ? ram_rdata : data_q;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      wr_idx_q <= '0;
      ram_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      wr_idx_q <= wr_idx_d;
      ram_en_q <= ram_en_d;
      wr_en_q  <= wr_en_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  assign ram_en   = ram_en_q;
  assign ram_addr = addr_q;
  assign wr_en    = wr_en_q;
  assign wr_idx   = wr_idx_q;
  // RAM data arrives in the wr_en cycle; the register only holds the last word while idle.
  assign wr_data  = wr_en_q ? ram_rdata : data_q;
  assign ram_done = done_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef RAM_CTRL_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;

  // Checksum accumulates every forwarded word, restarting on each accepted request.
  always_comb begin
    cks_d = cks_q;
    if (accept_s) begin
      cks_d = '0;
    end else if (wr_en_q) begin
      cks_d = cks_q + ram_rdata;
    end else begin
      cks_d = cks_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule
